// File: rtl/ctrl_posicion_display_pkg.sv
// Shared encodings for the display position / edit controller.
// Modes, FSM states and field indices are used by the top and its counters.
package ctrl_posicion_display_pkg;

    localparam logic [1:0] HORA  = 2'd0;
    localparam logic [1:0] FECHA = 2'd1;
    localparam logic [1:0] TIMER = 2'd2;

    localparam logic [0:0] VER    = 1'b0;
    localparam logic [0:0] EDITAR = 1'b1;

    localparam logic [1:0] POS_HORA_DIA = 2'd0;
    localparam logic [1:0] POS_MIN_MES  = 2'd1;
    localparam logic [1:0] POS_SEG_YEAR = 2'd2;

    function automatic logic [1:0] siguiente_modo(input logic [1:0] m);
        case (m)
            HORA:    return FECHA;
            FECHA:   return TIMER;
            default: return HORA;
        endcase
    endfunction

    // Returned as {f3, f2, f1}.
    function automatic logic [2:0] flags_modo(input logic [1:0] m);
        case (m)
            FECHA:   return 3'b010;
            TIMER:   return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_posicion_display_contador_mod3.sv
// Wrapping counter over the three display fields (0..2) with inc/dec/clear.
// Clear has priority; simultaneous inc and dec leave the value unchanged.
module contador_mod3
    import ctrl_posicion_display_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] valor
);

    localparam logic [W-1:0] PRIMERO = W'(POS_HORA_DIA);
    localparam logic [W-1:0] ULTIMO  = W'(POS_SEG_YEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valor <= PRIMERO;
        end else if (clr) begin
            valor <= PRIMERO;
        end else if (inc && !dec) begin
            valor <= (valor == ULTIMO) ? PRIMERO : valor + W'(1);
        end else if (dec && !inc) begin
            valor <= (valor == PRIMERO) ? ULTIMO : valor - W'(1);
        end
    end

endmodule

// File: rtl/ctrl_posicion_display.sv
// Display scan position, mode selection and field-edit controller.
//   state  | meaning
//   VER    | normal display; btn_modo cycles HORA/FECHA/TIMER
//   EDITAR | field edit; cursor moves, selected field blinks, idle timeout
module ctrl_posicion_display
    import ctrl_posicion_display_pkg::*;
#(
    parameter int P             = 2,
    parameter int BLINK_TICKS   = 250,
    parameter int TIMEOUT_TICKS = 15000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_refresh,
    input  logic         btn_modo,
    input  logic         btn_edit,
    input  logic         btn_izq,
    input  logic         btn_der,
    output logic         f1,
    output logic         f2,
    output logic         f3,
    output logic [P-1:0] posicion,
    output logic [P-1:0] cursor,
    output logic         edit_en,
    output logic         blink,
    output logic         apagar
);

    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    logic [1:0]    modo, modo_next;
    logic [0:0]    estado, estado_next;
    logic [2:0]    flags;
    logic [BW-1:0] cnt_blink;
    logic [TW-1:0] cnt_timeout;
    logic          editando, entra, sigue_editando, actividad, timeout_fin;

    assign editando  = (estado == EDITAR);
    assign entra     = !editando && btn_edit;
    assign actividad = btn_izq || btn_der || btn_edit;
    // A button in the terminal-count cycle counts as activity and restarts the wait.
    assign timeout_fin = editando && tick_refresh && !actividad
                         && (cnt_timeout == TW'(TIMEOUT_TICKS - 1));

    always_comb begin
        modo_next   = modo;
        estado_next = estado;
        if (!editando) begin
            if (btn_edit)
                estado_next = EDITAR;
            else if (btn_modo)
                modo_next = siguiente_modo(modo);
        end else if (btn_edit || timeout_fin) begin
            estado_next = VER;
        end
    end

    assign sigue_editando = editando && (estado_next == EDITAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            modo    <= HORA;
            flags   <= flags_modo(HORA);
            estado  <= VER;
            edit_en <= 1'b0;
        end else begin
            modo    <= modo_next;
            flags   <= flags_modo(modo_next);
            estado  <= estado_next;
            edit_en <= (estado_next == EDITAR);
        end
    end

    // Blink phase only runs while the edit continues; entering or leaving forces 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_blink <= '0;
            blink     <= 1'b0;
        end else if (!sigue_editando) begin
            cnt_blink <= '0;
            blink     <= 1'b0;
        end else if (tick_refresh) begin
            if (cnt_blink == BW'(BLINK_TICKS - 1)) begin
                cnt_blink <= '0;
                blink     <= ~blink;
            end else begin
                cnt_blink <= cnt_blink + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_timeout <= '0;
        end else if (!editando || actividad || timeout_fin) begin
            cnt_timeout <= '0;
        end else if (tick_refresh) begin
            cnt_timeout <= cnt_timeout + TW'(1);
        end
    end

    contador_mod3 #(.W(P)) u_posicion (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (tick_refresh),
        .dec   (1'b0),
        .valor (posicion)
    );

    contador_mod3 #(.W(P)) u_cursor (
        .clk   (clk),
        .reset (reset),
        .clr   (entra),
        .inc   (editando && btn_der && !btn_izq),
        .dec   (editando && btn_izq && !btn_der),
        .valor (cursor)
    );

    assign f1 = flags[0];
    assign f2 = flags[1];
    assign f3 = flags[2];

    assign apagar = edit_en && blink && (posicion == cursor);

endmodule

// File: doc/ctrl_posicion_display.md
CTRL_POSICION_DISPLAY -- requirements
Module: ctrl_posicion_display

Interface
REQ-001 Parameter P, default 2, width of posicion and cursor.
REQ-002 Parameter BLINK_TICKS, default 250, number of tick_refresh strobes per blink half-period.
REQ-003 Parameter TIMEOUT_TICKS, default 15000, number of tick_refresh strobes without a button press before edit mode exits automatically.
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick_refresh  input  1  one-cycle display-scan strobe.
REQ-007 btn_modo, btn_edit, btn_izq, btn_der  input  1 each  debounced one-cycle button pulses.
REQ-008 f1, f2, f3  output  1 each  one-hot mode flags: hora, fecha, timer.
REQ-009 posicion  output  P  field currently being scanned to the display mux.
REQ-010 cursor  output  P  field selected for editing.
REQ-011 edit_en  output  1  high while in EDITAR.
REQ-012 blink  output  1  blink phase; high means the selected field is blanked.
REQ-013 apagar  output  1  blank the current scan slot.

Function
REQ-014 The mode register SHALL hold HORA, FECHA or TIMER; f1/f2/f3 SHALL be registered and exactly one-hot.
REQ-015 The state register SHALL hold VER or EDITAR; edit_en SHALL be high exactly when the state is EDITAR.
REQ-016 In VER, btn_modo SHALL advance the mode HORA->FECHA->TIMER->HORA, with the flags updating one cycle later.
REQ-017 In EDITAR, btn_modo SHALL be ignored.
REQ-018 In VER, btn_edit SHALL enter EDITAR and clear cursor, blink, the blink counter and the timeout counter.
REQ-019 In EDITAR, btn_edit SHALL return the block to VER.
REQ-020 If btn_edit and btn_modo are high in the same cycle in VER, btn_edit SHALL win and the mode SHALL remain unchanged.
REQ-021 In EDITAR, btn_der SHALL step cursor 0->1->2->0 and btn_izq SHALL step it 0->2->1->0.
REQ-022 If btn_izq and btn_der are high in the same cycle, cursor SHALL NOT change.
REQ-023 In VER, btn_izq and btn_der SHALL be ignored.
REQ-024 On each tick_refresh, posicion SHALL step 0->1->2->0 in every state; the value 3 SHALL never be output.
REQ-025 In EDITAR, the blink counter SHALL count tick_refresh strobes from 0 to BLINK_TICKS-1, then wrap to 0 and toggle blink.
REQ-026 In VER, blink and the blink counter SHALL be held at 0.
REQ-027 In EDITAR, the timeout counter SHALL increment on each tick_refresh and SHALL clear on any of btn_izq, btn_der or btn_edit.
REQ-028 When the timeout counter reaches TIMEOUT_TICKS-1 and a tick_refresh occurs, the state SHALL go to VER.
REQ-029 apagar SHALL equal edit_en AND blink AND (posicion == cursor), decoded from registers with no input-to-output combinational path.
REQ-030 All outputs except apagar SHALL be registered, with single-cycle latency from the triggering input.

Reset
REQ-031 On reset, the block SHALL immediately load: mode HORA (f1=1, f2=0, f3=0), state VER, posicion=0, cursor=0, blink=0, edit_en=0, apagar=0, and all counters 0.
REQ-032 Reset asserted during EDITAR SHALL abort the edit and apply the reset values of REQ-031 with no residual state.
REQ-033 Inputs SHALL be ignored while reset is high; normal operation SHALL resume on the first clk edge after reset deasserts.

Structure
REQ-034 The mode encodings (HORA, FECHA, TIMER), state encodings (VER, EDITAR) and field constants (POS_HORA_DIA=0, POS_MIN_MES=1, POS_SEG_YEAR=2) SHALL live in a shared package.
REQ-035 posicion and cursor SHALL each use one instance of the sub-module contador_mod3, which provides a wrapping mod-3 counter with inc/dec/clear.
REQ-036 The blink and timeout counters and the FSM SHALL be implemented inline.

Verification (BLINK_TICKS=4, TIMEOUT_TICKS=8)
REQ-037 Reset, then 7 tick_refresh -> posicion sequence 1,2,0,1,2,0,1; f1=1; edit_en=0.
REQ-038 Three btn_modo pulses in VER -> flags f2, then f3, then f1; btn_modo+btn_edit in the same cycle -> EDITAR with mode unchanged.
REQ-039 btn_edit, then btn_izq -> cursor=2; then btn_der twice -> cursor=1; btn_izq+btn_der together -> cursor stays 1.
REQ-040 In EDITAR, 8 tick_refresh -> blink toggles after tick 4 and after tick 8; apagar=1 only when posicion==cursor during blink=1.
REQ-041 In EDITAR, 8 tick_refresh with no button -> edit_en=0 one cycle after the 8th tick; a btn_der at tick 5 -> timeout is delayed until tick 13.
REQ-042 Assert reset mid-EDITAR with cursor=2, mode FECHA -> all outputs at their reset values before the next clk edge.
